// File: rtl/win_checker_if.sv
// rtl/win_checker_if.sv - start/finish handshake, board snapshot input and result bundle
interface win_checker_if #(
   parameter int BOARD_W = 15,
   parameter int BOARD_H = 15,
   parameter int X_BITS  = 4,
   parameter int Y_BITS  = 4
);
   logic                           in_cont_signal;
   logic [2*BOARD_W*BOARD_H-1:0]   board;
   logic                           out_cont_signal;
   logic [1:0]                     gaming_status;
   logic [X_BITS-1:0]              win_x;
   logic [Y_BITS-1:0]              win_y;
   logic [1:0]                     win_dir;
   logic                           busy;

   modport master (
      output in_cont_signal, board,
      input  out_cont_signal, gaming_status, win_x, win_y, win_dir, busy
   );

   modport slave (
      input  in_cont_signal, board,
      output out_cont_signal, gaming_status, win_x, win_y, win_dir, busy
   );
endinterface

// File: rtl/win_checker.sv
// rtl/win_checker.sv - one-cell-per-clock raster scan of a latched board for five-in-a-row or draw
module win_checker #(
   parameter int BOARD_W = 15,
   parameter int BOARD_H = 15,
   parameter int WIN_LEN = 5,
   parameter int X_BITS  = 4,
   parameter int Y_BITS  = 4
) (
   input  logic         Clck,
   input  logic         Reset,
   win_checker_if.slave bus
);
   localparam int CELLS = BOARD_W * BOARD_H;
   localparam int IDX_W = $clog2(2 * CELLS);
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(BOARD_W - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(BOARD_H - 1);
   localparam logic [1:0] BLACK = 2'b01;
   localparam logic [1:0] WHITE = 2'b10;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t               state_q, state_d;
   logic [2*CELLS-1:0]   snap_q, snap_d;
   logic [X_BITS-1:0]    x_q, x_d;
   logic [Y_BITS-1:0]    y_q, y_d;
   logic                 any_empty_q, any_empty_d;
   logic [1:0]           status_q, status_d;
   logic [X_BITS-1:0]    win_x_q, win_x_d;
   logic [Y_BITS-1:0]    win_y_q, win_y_d;
   logic [1:0]           win_dir_q, win_dir_d;
   logic                 pulse_q, pulse_d;

   logic [1:0]           origin;
   logic                 hit;
   logic [1:0]           hit_dir;
   logic                 empty_now;

   // Off-board coordinates read as empty, so a run leaving the board can never match a stone.
   function automatic logic [1:0] cell_at(input logic [2*CELLS-1:0] s, input int cx, input int cy);
      logic [IDX_W-1:0] idx;
      if (cx < 0 || cx >= BOARD_W || cy < 0 || cy >= BOARD_H) return 2'b00;
      idx = IDX_W'(2 * (cy * BOARD_W + cx));
      return s[idx +: 2];
   endfunction

   function automatic int dx(input int d);
      case (d)
         0, 2:    return 1;
         3:       return -1;
         default: return 0;
      endcase
   endfunction

   function automatic int dy(input int d);
      return (d == 0) ? 0 : 1;
   endfunction

   function automatic logic run_hits(input logic [2*CELLS-1:0] s, input int ox, input int oy,
                                     input int d, input logic [1:0] col);
      logic ok;
      ok = (col == BLACK) || (col == WHITE);
      for (int k = 0; k < WIN_LEN; k++) begin
         if (cell_at(s, ox + k * dx(d), oy + k * dy(d)) != col) ok = 1'b0;
      end
      return ok;
   endfunction

   // Descending sweep so the lowest-numbered hitting direction is the one left standing.
   always_comb begin
      origin  = cell_at(snap_q, int'(x_q), int'(y_q));
      hit     = 1'b0;
      hit_dir = 2'd0;
      for (int d = 3; d >= 0; d--) begin
         if (run_hits(snap_q, int'(x_q), int'(y_q), d, origin)) begin
            hit     = 1'b1;
            hit_dir = 2'(d);
         end
      end
   end

   always_ff @(posedge Clck or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         any_empty_q <= 1'b0;
         status_q    <= 2'b00;
         win_x_q     <= '0;
         win_y_q     <= '0;
         win_dir_q   <= 2'd0;
         pulse_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         x_q         <= x_d;
         y_q         <= y_d;
         any_empty_q <= any_empty_d;
         status_q    <= status_d;
         win_x_q     <= win_x_d;
         win_y_q     <= win_y_d;
         win_dir_q   <= win_dir_d;
         pulse_q     <= pulse_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      x_d         = x_q;
      y_d         = y_q;
      any_empty_d = any_empty_q;
      status_d    = status_q;
      win_x_d     = win_x_q;
      win_y_d     = win_y_q;
      win_dir_d   = win_dir_q;
      pulse_d     = 1'b0;
      empty_now   = any_empty_q | (origin == 2'b00) | (origin == 2'b11);
      case (state_q)
         IDLE: begin
            if (bus.in_cont_signal) begin
               snap_d      = bus.board;
               x_d         = '0;
               y_d         = '0;
               any_empty_d = 1'b0;
               state_d     = SCAN;
            end
         end
         SCAN: begin
            if (hit) begin
               status_d  = origin;
               win_x_d   = x_q;
               win_y_d   = y_q;
               win_dir_d = hit_dir;
               pulse_d   = 1'b1;
               state_d   = IDLE;
            end else begin
               any_empty_d = empty_now;
               if (x_q == X_LAST && y_q == Y_LAST) begin
                  status_d  = empty_now ? 2'b00 : 2'b11;
                  win_x_d   = '0;
                  win_y_d   = '0;
                  win_dir_d = 2'd0;
                  pulse_d   = 1'b1;
                  state_d   = IDLE;
               end else if (x_q == X_LAST) begin
                  x_d = '0;
                  y_d = y_q + 1'b1;
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.out_cont_signal = pulse_q;
      bus.gaming_status   = status_q;
      bus.win_x           = win_x_q;
      bus.win_y           = win_y_q;
      bus.win_dir         = win_dir_q;
      bus.busy            = (state_q == SCAN);
   end
endmodule

// File: tb/tb_win_checker.sv
// tb/tb_win_checker.sv - directed scans checked against a rule-level board model and literal results
module tb_win_checker;
   localparam int W = 15;
   localparam int H = 15;
   localparam int NB = 2 * W * H;

   typedef struct packed {
      logic [1:0] st;
      logic [3:0] x;
      logic [3:0] y;
      logic [1:0] d;
      int         lat;
   } res_t;

   logic Clck;
   logic Reset;
   int   n_cmp;
   int   n_fail;

   win_checker_if #(.BOARD_W(W), .BOARD_H(H), .X_BITS(4), .Y_BITS(4)) bus ();

   win_checker #(.BOARD_W(W), .BOARD_H(H), .WIN_LEN(5), .X_BITS(4), .Y_BITS(4)) dut (
      .Clck  (Clck),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clck = 1'b0;
   always #5 Clck = ~Clck;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [NB-1:0] put(input logic [NB-1:0] b, input int x, input int y, input logic [1:0] c);
      b[2*(y*W+x) +: 2] = c;
      return b;
   endfunction

   // Winner = first stone in raster order owning five equal in-board cells along +x, +y, +x+y, -x+y.
   function automatic res_t model_eval(input logic [NB-1:0] b);
      int   c[H][W];
      int   dxs[4] = '{1, 0, 1, -1};
      int   dys[4] = '{0, 1, 1, 1};
      bit   empty;
      res_t r;
      empty = 0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            c[y][x] = (b[2*(y*W+x) +: 2] == 2'b11) ? 0 : int'(b[2*(y*W+x) +: 2]);
            if (c[y][x] == 0) empty = 1;
         end
      for (int i = 0; i < W * H; i++) begin
         int x = i % W;
         int y = i / W;
         if (c[y][x] != 0) begin
            for (int d = 0; d < 4; d++) begin
               bit ok = 1;
               for (int k = 0; k < 5; k++) begin
                  int nx = x + k * dxs[d];
                  int ny = y + k * dys[d];
                  if (nx < 0 || nx >= W || ny >= H) ok = 0;
                  else if (c[ny][nx] != c[y][x]) ok = 0;
               end
               if (ok) begin
                  r.st = 2'(c[y][x]); r.x = 4'(x); r.y = 4'(y); r.d = 2'(d); r.lat = i + 1;
                  return r;
               end
            end
         end
      end
      r.st = empty ? 2'b00 : 2'b11; r.x = 0; r.y = 0; r.d = 0; r.lat = W * H;
      return r;
   endfunction

   logic       m_busy, m_pulse;
   int         m_left;
   res_t       m_pend, m_out;

   always @(posedge Clck or posedge Reset) begin
      if (Reset) begin
         m_busy  <= 1'b0;
         m_pulse <= 1'b0;
         m_left  <= 0;
         m_pend  <= '0;
         m_out   <= '0;
      end else begin
         m_pulse <= 1'b0;
         if (!m_busy) begin
            if (bus.in_cont_signal) begin
               m_busy <= 1'b1;
               m_pend <= model_eval(bus.board);
               m_left <= model_eval(bus.board).lat;
            end
         end else if (m_left == 1) begin
            m_busy  <= 1'b0;
            m_pulse <= 1'b1;
            m_out   <= m_pend;
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   always @(negedge Clck) begin
      chk("cyc_pulse",  bus.out_cont_signal, m_pulse);
      chk("cyc_busy",   bus.busy,            m_busy);
      chk("cyc_status", bus.gaming_status,   m_out.st);
      chk("cyc_win_x",  bus.win_x,           m_out.x);
      chk("cyc_win_y",  bus.win_y,           m_out.y);
      chk("cyc_dir",    bus.win_dir,         m_out.d);
   end

   task automatic run_test(input string name, input logic [NB-1:0] b, input logic [1:0] es,
                           input int ex, input int ey, input int ed, input int el, input bit hold,
                           input int mut_at, input logic [NB-1:0] mut_b);
      int cyc;
      bit seen;
      @(posedge Clck);
      #2 bus.board = b;
      bus.in_cont_signal = 1'b1;
      @(posedge Clck);
      #2 if (!hold) bus.in_cont_signal = 1'b0;
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 300) begin
         @(posedge Clck);
         cyc++;
         #1 if (bus.out_cont_signal) seen = 1;
         if (cyc == mut_at) bus.board = mut_b;
      end
      bus.in_cont_signal = 1'b0;
      chk({name, "_lat"},    cyc,               el);
      chk({name, "_status"}, bus.gaming_status, es);
      chk({name, "_x"},      bus.win_x,         ex);
      chk({name, "_y"},      bus.win_y,         ey);
      chk({name, "_dir"},    bus.win_dir,       ed);
      chk({name, "_model"},  m_out.st,          es);
      @(posedge Clck);
      #1 chk({name, "_idle"}, {bus.busy, bus.out_cont_signal}, 0);
   endtask

   logic [NB-1:0] b_empty, b_row, b_col, b_diag, b_wrap, b_full;
   int pulses;

   initial begin
      n_cmp = 0;
      n_fail = 0;
      Reset = 1'b1;
      bus.in_cont_signal = 1'b0;
      bus.board = '0;
      b_empty = '0;
      b_row = '0; b_col = '0; b_diag = '0; b_wrap = '0; b_full = '0;
      for (int i = 3; i <= 7; i++)   b_row = put(b_row, i, 7, 2'b01);
      for (int i = 10; i <= 14; i++) b_col = put(b_col, 14, i, 2'b10);
      for (int i = 0; i <= 4; i++)   b_diag = put(b_diag, 4 - i, i, 2'b10);
      for (int i = 12; i <= 14; i++) b_wrap = put(b_wrap, i, 3, 2'b01);
      b_wrap = put(b_wrap, 0, 4, 2'b01);
      b_wrap = put(b_wrap, 1, 4, 2'b01);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            b_full = put(b_full, x, y, ((((x >> 1) + y) & 1) != 0) ? 2'b10 : 2'b01);
      #23 Reset = 1'b0;
      @(negedge Clck);
      chk("reset_outputs", {bus.out_cont_signal, bus.busy, bus.gaming_status, bus.win_x, bus.win_y, bus.win_dir}, 0);

      run_test("empty",  b_empty, 2'b00, 0,  0,  0, 225, 0, -1, '0);
      run_test("row",    b_row,   2'b01, 3,  7,  0, 109, 0, -1, '0);
      run_test("row2",   b_row,   2'b01, 3,  7,  0, 109, 0, -1, '0);
      run_test("col",    b_col,   2'b10, 14, 10, 1, 165, 1, -1, '0);
      run_test("adiag",  b_diag,  2'b10, 4,  0,  3, 5,   0, -1, '0);
      run_test("nowrap", b_wrap,  2'b00, 0,  0,  0, 225, 0, -1, '0);
      run_test("draw",   b_full,  2'b11, 0,  0,  0, 225, 0, -1, '0);
      run_test("mutate", b_empty, 2'b00, 0,  0,  0, 225, 0, 10, b_row);
      run_test("col3",   b_col,   2'b10, 14, 10, 1, 165, 0, -1, '0);

      @(posedge Clck);
      #2 bus.board = b_empty;
      bus.in_cont_signal = 1'b1;
      @(posedge Clck);
      #2 bus.in_cont_signal = 1'b0;
      repeat (20) @(posedge Clck);
      #2 Reset = 1'b1;
      #1 chk("midreset_outputs", {bus.out_cont_signal, bus.busy, bus.gaming_status, bus.win_x, bus.win_y, bus.win_dir}, 0);
      #4 Reset = 1'b0;
      pulses = 0;
      repeat (250) begin
         @(posedge Clck);
         #1 if (bus.out_cont_signal) pulses++;
      end
      chk("midreset_no_pulse", pulses, 0);
      run_test("after_rst", b_diag, 2'b10, 4, 0, 3, 5, 0, -1, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
